// File: rtl/decode_stage_pipelined_if.sv
// Decode-stage bus: fetch-side handshake, writeback port, EX hazard
// feedback, and the registered ID/EX pipeline outputs.
interface decode_stage_pipelined_if #(
  parameter int WIDTH            = 32,
  parameter int ADDRESSWIDTH     = 4,
  parameter int OPCODEWIDTH      = 4,
  parameter int INSTRUCTIONWIDTH = 24
);
  // fetch side
  logic [INSTRUCTIONWIDTH-1:0] instruction;
  logic [WIDTH-1:0]            PC;
  logic                        inValid;
  logic                        inReady;
  // writeback
  logic                        writeEnable;
  logic [ADDRESSWIDTH-1:0]     writeAddress;
  logic [WIDTH-1:0]            dataToSave;
  // hazard / control from EX
  logic                        exMemRead;
  logic [ADDRESSWIDTH-1:0]     exDestAddress;
  logic                        flush;
  // ID/EX pipeline register
  logic                        outReady;
  logic                        outValid;
  logic [OPCODEWIDTH-1:0]      opcode;
  logic [ADDRESSWIDTH-1:0]     regDestinationAddress;
  logic [ADDRESSWIDTH-1:0]     reg1Address;
  logic [ADDRESSWIDTH-1:0]     reg2Address;
  logic [WIDTH-1:0]            reg1Content;
  logic [WIDTH-1:0]            reg2Content;
  logic [WIDTH-1:0]            inmediate;
  logic [WIDTH-1:0]            pcOut;

  // surrounding pipeline (fetch, writeback, execute)
  modport master (
    output instruction, PC, inValid, writeEnable, writeAddress, dataToSave,
           exMemRead, exDestAddress, flush, outReady,
    input  inReady, outValid, opcode, regDestinationAddress, reg1Address,
           reg2Address, reg1Content, reg2Content, inmediate, pcOut
  );

  // the decode stage itself
  modport slave (
    input  instruction, PC, inValid, writeEnable, writeAddress, dataToSave,
           exMemRead, exDestAddress, flush, outReady,
    output inReady, outValid, opcode, regDestinationAddress, reg1Address,
           reg2Address, reg1Content, reg2Content, inmediate, pcOut
  );
endinterface

// File: rtl/decode_stage_pipelined.sv
// Pipelined decode stage: field extraction, register file with writeback
// bypass and PC alias, load-use hazard stall, flush, and a valid/ready
// ID/EX pipeline register.
module decode_stage_pipelined #(
  parameter int WIDTH            = 32,
  parameter int REGNUM           = 16,
  parameter int ADDRESSWIDTH     = 4,
  parameter int OPCODEWIDTH      = 4,
  parameter int INSTRUCTIONWIDTH = 24,
  parameter int IMMWIDTH         = 16,
  parameter int SIGNEXT          = 0
) (
  input logic                      clock,
  input logic                      reset,
  decode_stage_pipelined_if.slave  bus
);

  // highest register index aliases the PC and is never stored
  localparam logic [ADDRESSWIDTH-1:0] PC_ADDR   = ADDRESSWIDTH'(REGNUM - 1);
  localparam logic [ADDRESSWIDTH:0]   REG_LIMIT = (ADDRESSWIDTH + 1)'(REGNUM);

  localparam int RD_MSB  = INSTRUCTIONWIDTH - OPCODEWIDTH - 1;
  localparam int RS1_MSB = RD_MSB - ADDRESSWIDTH;
  localparam int RS2_MSB = RS1_MSB - ADDRESSWIDTH;

  logic [OPCODEWIDTH-1:0]  op_field;
  logic [ADDRESSWIDTH-1:0] rd_field;
  logic [ADDRESSWIDTH-1:0] rs1_field;
  logic [ADDRESSWIDTH-1:0] rs2_field;
  logic [IMMWIDTH-1:0]     imm_field;
  logic [WIDTH-1:0]        imm_ext;

  assign op_field  = bus.instruction[INSTRUCTIONWIDTH-1 -: OPCODEWIDTH];
  assign rd_field  = bus.instruction[RD_MSB -: ADDRESSWIDTH];
  assign rs1_field = bus.instruction[RS1_MSB -: ADDRESSWIDTH];
  assign rs2_field = bus.instruction[RS2_MSB -: ADDRESSWIDTH];
  assign imm_field = bus.instruction[IMMWIDTH-1:0];

  generate
    if (SIGNEXT != 0) begin : g_imm_sign
      assign imm_ext = {{(WIDTH-IMMWIDTH){imm_field[IMMWIDTH-1]}}, imm_field};
    end else begin : g_imm_zero
      assign imm_ext = {{(WIDTH-IMMWIDTH){1'b0}}, imm_field};
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] rf_reg [REGNUM];
  logic             rf_wr_en;

  // PC-alias and out-of-range writes are dropped
  assign rf_wr_en = bus.writeEnable && (bus.writeAddress != PC_ADDR) &&
                    ({1'b0, bus.writeAddress} < REG_LIMIT);

  // writeback runs every cycle regardless of stall, flush or handshake
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REGNUM; i++) rf_reg[i] <= '0;
    end else if (rf_wr_en) begin
      rf_reg[bus.writeAddress] <= bus.dataToSave;
    end
  end

  // two identical read ports: PC alias, range check, bypass, stored value
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic [ADDRESSWIDTH-1:0] addr;
      logic [WIDTH-1:0]        data;

      assign addr = (gi == 0) ? rs1_field : rs2_field;

      // select operand source in priority order
      always_comb begin
        data = '0;
        if (addr == PC_ADDR) begin
          data = bus.PC;
        end else if ({1'b0, addr} >= REG_LIMIT) begin
          data = '0;
        end else if (bus.writeEnable && (bus.writeAddress == addr)) begin
          data = bus.dataToSave;
        end else begin
          data = rf_reg[addr];
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Handshake and hazard
  // ---------------------------------------------------------------------
  logic out_valid_reg;
  logic hazard;
  logic advance;

  assign hazard  = bus.inValid && bus.exMemRead && (bus.exDestAddress != PC_ADDR) &&
                   ((rs1_field == bus.exDestAddress) || (rs2_field == bus.exDestAddress));
  assign advance = !out_valid_reg || bus.outReady;
  assign bus.inReady = advance && !hazard;

  // ---------------------------------------------------------------------
  // ID/EX pipeline register
  // ---------------------------------------------------------------------
  logic [OPCODEWIDTH-1:0]  opcode_reg;
  logic [ADDRESSWIDTH-1:0] rd_reg;
  logic [ADDRESSWIDTH-1:0] rs1_reg;
  logic [ADDRESSWIDTH-1:0] rs2_reg;
  logic [WIDTH-1:0]        rs1_data_reg;
  logic [WIDTH-1:0]        rs2_data_reg;
  logic [WIDTH-1:0]        imm_reg;
  logic [WIDTH-1:0]        pc_reg;

  // flush beats hazard bubble beats capture; otherwise hold
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_reg <= 1'b0;
      opcode_reg    <= '0;
      rd_reg        <= '0;
      rs1_reg       <= '0;
      rs2_reg       <= '0;
      rs1_data_reg  <= '0;
      rs2_data_reg  <= '0;
      imm_reg       <= '0;
      pc_reg        <= '0;
    end else if (bus.flush) begin
      out_valid_reg <= 1'b0;
    end else if (advance && hazard) begin
      out_valid_reg <= 1'b0;
    end else if (advance) begin
      out_valid_reg <= bus.inValid;
      opcode_reg    <= op_field;
      rd_reg        <= rd_field;
      rs1_reg       <= rs1_field;
      rs2_reg       <= rs2_field;
      rs1_data_reg  <= g_rd[0].data;
      rs2_data_reg  <= g_rd[1].data;
      imm_reg       <= imm_ext;
      pc_reg        <= bus.PC;
    end
  end

  assign bus.outValid              = out_valid_reg;
  assign bus.opcode                = opcode_reg;
  assign bus.regDestinationAddress = rd_reg;
  assign bus.reg1Address           = rs1_reg;
  assign bus.reg2Address           = rs2_reg;
  assign bus.reg1Content           = rs1_data_reg;
  assign bus.reg2Content           = rs2_data_reg;
  assign bus.inmediate             = imm_reg;
  assign bus.pcOut                 = pc_reg;

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Directed bench for decode_stage_pipelined: one task per scenario,
// inline comparisons against hand-computed values.
module tb_decode_stage_pipelined;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  decode_stage_pipelined_if bus0 ();
  decode_stage_pipelined_if bus1 ();

  decode_stage_pipelined u_dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus0)
  );

  decode_stage_pipelined #(.SIGNEXT(1)) u_dut_sx (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus1)
  );

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus0.instruction = '0; bus0.PC = '0; bus0.inValid = 1'b0;
    bus0.writeEnable = 1'b0; bus0.writeAddress = '0; bus0.dataToSave = '0;
    bus0.exMemRead = 1'b0; bus0.exDestAddress = '0; bus0.flush = 1'b0;
    bus0.outReady = 1'b0;
    bus1.instruction = '0; bus1.PC = '0; bus1.inValid = 1'b0;
    bus1.writeEnable = 1'b0; bus1.writeAddress = '0; bus1.dataToSave = '0;
    bus1.exMemRead = 1'b0; bus1.exDestAddress = '0; bus1.flush = 1'b0;
    bus1.outReady = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    vectors++; if (bus0.outValid !== 1'b0) begin miscompares++; $display("FAIL reset_outValid got %b exp 0", bus0.outValid); end
    vectors++; if (bus0.opcode !== 4'h0) begin miscompares++; $display("FAIL reset_opcode got %h exp 0", bus0.opcode); end
    vectors++; if (bus0.pcOut !== 32'h0) begin miscompares++; $display("FAIL reset_pcOut got %h exp 0", bus0.pcOut); end
    vectors++; if (bus0.inReady !== 1'b1) begin miscompares++; $display("FAIL reset_inReady got %b exp 1", bus0.inReady); end
    rst_n = 1'b1;
    $display("txn reset: outValid=%b inReady=%b", bus0.outValid, bus0.inReady);
  endtask

  task automatic test_basic();
    bus0.instruction = 24'h2345AB; bus0.PC = 32'h40; bus0.inValid = 1'b1; bus0.outReady = 1'b1;
    tick();
    vectors++; if (bus0.outValid !== 1'b1) begin miscompares++; $display("FAIL basic_outValid got %b exp 1", bus0.outValid); end
    vectors++; if (bus0.opcode !== 4'h2) begin miscompares++; $display("FAIL basic_opcode got %h exp 2", bus0.opcode); end
    vectors++; if (bus0.regDestinationAddress !== 4'h3) begin miscompares++; $display("FAIL basic_rd got %h exp 3", bus0.regDestinationAddress); end
    vectors++; if (bus0.reg1Address !== 4'h4 || bus0.reg2Address !== 4'h5) begin miscompares++; $display("FAIL basic_rs got %h/%h exp 4/5", bus0.reg1Address, bus0.reg2Address); end
    vectors++; if (bus0.reg1Content !== 32'h0) begin miscompares++; $display("FAIL basic_reg1 got %h exp 0", bus0.reg1Content); end
    vectors++; if (bus0.inmediate !== 32'h000045AB) begin miscompares++; $display("FAIL basic_imm got %h exp 000045ab", bus0.inmediate); end
    vectors++; if (bus0.pcOut !== 32'h40) begin miscompares++; $display("FAIL basic_pcOut got %h exp 40", bus0.pcOut); end
    $display("txn basic: opcode=%h rd=%h imm=%h", bus0.opcode, bus0.regDestinationAddress, bus0.inmediate);
  endtask

  task automatic test_bypass();
    bus0.writeEnable = 1'b1; bus0.writeAddress = 4'h4; bus0.dataToSave = 32'hDEADBEEF;
    bus0.instruction = 24'h164700;
    tick();
    vectors++; if (bus0.reg1Content !== 32'hDEADBEEF) begin miscompares++; $display("FAIL bypass_reg1 got %h exp deadbeef", bus0.reg1Content); end
    vectors++; if (bus0.reg2Content !== 32'h0) begin miscompares++; $display("FAIL bypass_reg2 got %h exp 0", bus0.reg2Content); end
    bus0.writeEnable = 1'b0;
    bus0.instruction = 24'h100400;
    tick();
    vectors++; if (bus0.reg2Content !== 32'hDEADBEEF) begin miscompares++; $display("FAIL stored_reg2 got %h exp deadbeef", bus0.reg2Content); end
    $display("txn bypass: reg2=%h", bus0.reg2Content);
  endtask

  task automatic test_pc_alias();
    bus0.writeEnable = 1'b1; bus0.writeAddress = 4'hF; bus0.dataToSave = 32'h5;
    bus0.PC = 32'h100; bus0.instruction = 24'h31F000;
    tick();
    vectors++; if (bus0.reg1Content !== 32'h100) begin miscompares++; $display("FAIL pcalias_bypass got %h exp 100", bus0.reg1Content); end
    bus0.writeEnable = 1'b0;
    bus0.PC = 32'h200; bus0.instruction = 24'h300F00;
    tick();
    vectors++; if (bus0.reg2Content !== 32'h200) begin miscompares++; $display("FAIL pcalias_read got %h exp 200", bus0.reg2Content); end
    vectors++; if (bus0.pcOut !== 32'h200) begin miscompares++; $display("FAIL pcalias_pcOut got %h exp 200", bus0.pcOut); end
    $display("txn pc_alias: reg2=%h", bus0.reg2Content);
  endtask

  task automatic test_hazard();
    bus0.exMemRead = 1'b1; bus0.exDestAddress = 4'h4;
    bus0.PC = 32'h300; bus0.instruction = 24'h425400;
    #1;
    vectors++; if (bus0.inReady !== 1'b0) begin miscompares++; $display("FAIL hazard_inReady got %b exp 0", bus0.inReady); end
    tick();
    vectors++; if (bus0.outValid !== 1'b0) begin miscompares++; $display("FAIL hazard_bubble got %b exp 0", bus0.outValid); end
    bus0.exMemRead = 1'b0;
    #1;
    vectors++; if (bus0.inReady !== 1'b1) begin miscompares++; $display("FAIL hazard_release got %b exp 1", bus0.inReady); end
    tick();
    vectors++; if (bus0.outValid !== 1'b1 || bus0.opcode !== 4'h4) begin miscompares++; $display("FAIL hazard_accept got v=%b op=%h exp v=1 op=4", bus0.outValid, bus0.opcode); end
    vectors++; if (bus0.reg2Content !== 32'hDEADBEEF) begin miscompares++; $display("FAIL hazard_reg2 got %h exp deadbeef", bus0.reg2Content); end
    // a load targeting the PC alias never stalls
    bus0.exMemRead = 1'b1; bus0.exDestAddress = 4'hF; bus0.instruction = 24'h42FF00;
    #1;
    vectors++; if (bus0.inReady !== 1'b1) begin miscompares++; $display("FAIL hazard_pcdest got %b exp 1", bus0.inReady); end
    tick();
    bus0.exMemRead = 1'b0;
    vectors++; if (bus0.reg1Content !== 32'h300) begin miscompares++; $display("FAIL hazard_pcdest_reg1 got %h exp 300", bus0.reg1Content); end
    $display("txn hazard: outValid=%b opcode=%h", bus0.outValid, bus0.opcode);
  endtask

  task automatic test_stall_flush();
    bus0.outReady = 1'b0; bus0.PC = 32'h400; bus0.instruction = 24'h512300;
    #1;
    vectors++; if (bus0.inReady !== 1'b0) begin miscompares++; $display("FAIL stall_inReady got %b exp 0", bus0.inReady); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (bus0.outValid !== 1'b1 || bus0.opcode !== 4'h4 || bus0.pcOut !== 32'h300) begin miscompares++; $display("FAIL stall_hold%0d got v=%b op=%h pc=%h exp v=1 op=4 pc=300", i, bus0.outValid, bus0.opcode, bus0.pcOut); end
      vectors++; if (bus0.inReady !== 1'b0) begin miscompares++; $display("FAIL stall_inReady%0d got %b exp 0", i, bus0.inReady); end
    end
    bus0.flush = 1'b1;
    tick();
    vectors++; if (bus0.outValid !== 1'b0) begin miscompares++; $display("FAIL flush_outValid got %b exp 0", bus0.outValid); end
    bus0.flush = 1'b0;
    #1;
    vectors++; if (bus0.inReady !== 1'b1) begin miscompares++; $display("FAIL flush_inReady got %b exp 1", bus0.inReady); end
    $display("txn stall_flush: outValid=%b inReady=%b", bus0.outValid, bus0.inReady);
  endtask

  task automatic test_back_to_back();
    logic [23:0] ins;
    logic [3:0]  op;
    bus0.outReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op = 4'(6 + i);
      ins = {op, 4'h1, 4'h2, 4'h3, 8'h00};
      bus0.instruction = ins; bus0.PC = 32'(32'h500 + i);
      tick();
      vectors++; if (bus0.outValid !== 1'b1 || bus0.opcode !== op || bus0.pcOut !== 32'(32'h500 + i)) begin miscompares++; $display("FAIL b2b_%0d got v=%b op=%h pc=%h exp v=1 op=%h pc=%h", i, bus0.outValid, bus0.opcode, bus0.pcOut, op, 32'h500 + i); end
      $display("txn back_to_back %0d: opcode=%h pc=%h", i, bus0.opcode, bus0.pcOut);
    end
  endtask

  task automatic test_signext();
    bus0.instruction = 24'h018001; bus1.instruction = 24'h018001;
    bus1.inValid = 1'b1; bus1.outReady = 1'b1;
    tick();
    vectors++; if (bus0.inmediate !== 32'h00008001) begin miscompares++; $display("FAIL zeroext got %h exp 00008001", bus0.inmediate); end
    vectors++; if (bus1.inmediate !== 32'hFFFF8001) begin miscompares++; $display("FAIL signext got %h exp ffff8001", bus1.inmediate); end
    vectors++; if (bus1.outValid !== 1'b1) begin miscompares++; $display("FAIL signext_outValid got %b exp 1", bus1.outValid); end
    bus1.inValid = 1'b0;
    $display("txn signext: zero=%h sign=%h", bus0.inmediate, bus1.inmediate);
  endtask

  task automatic test_reset_midstream();
    bus0.writeEnable = 1'b1; bus0.writeAddress = 4'h6; bus0.dataToSave = 32'h0000CAFE;
    bus0.PC = 32'h600; bus0.instruction = 24'h906400;
    tick();
    vectors++; if (bus0.outValid !== 1'b1 || bus0.reg1Content !== 32'h0000CAFE) begin miscompares++; $display("FAIL midrst_pre got v=%b r1=%h exp v=1 r1=0000cafe", bus0.outValid, bus0.reg1Content); end
    bus0.writeEnable = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    vectors++; if (bus0.outValid !== 1'b0 || bus0.opcode !== 4'h0 || bus0.reg1Content !== 32'h0 || bus0.pcOut !== 32'h0) begin miscompares++; $display("FAIL midrst_async got v=%b op=%h r1=%h pc=%h exp all 0", bus0.outValid, bus0.opcode, bus0.reg1Content, bus0.pcOut); end
    tick();
    rst_n = 1'b1;
    tick();
    vectors++; if (bus0.outValid !== 1'b1 || bus0.opcode !== 4'h9) begin miscompares++; $display("FAIL midrst_resume got v=%b op=%h exp v=1 op=9", bus0.outValid, bus0.opcode); end
    vectors++; if (bus0.reg1Content !== 32'h0 || bus0.reg2Content !== 32'h0) begin miscompares++; $display("FAIL midrst_rf_clear got r1=%h r2=%h exp 0/0", bus0.reg1Content, bus0.reg2Content); end
    $display("txn reset_midstream: reg1=%h reg2=%h", bus0.reg1Content, bus0.reg2Content);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bypass();
    test_pc_alias();
    test_hazard();
    test_stall_flush();
    test_back_to_back();
    test_signext();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decode_stage_pipelined.md
Name: decode_stage_pipelined

Overview:
Parametrised successor to the combinational decode stage. It splits an instruction into opcode, register addresses and immediate, and reads an internal register file. The read port bypasses same-cycle writeback data. Results are registered into an ID/EX pipeline register with a valid/ready handshake, load-use hazard stalling and flush. It sits between fetch and execute in the pipelined processor.

Parameters:
WIDTH, 32, datapath width
REGNUM, 16, number of architectural registers; index REGNUM-1 is the PC alias
ADDRESSWIDTH, 4, register address width (2**ADDRESSWIDTH >= REGNUM)
OPCODEWIDTH, 4, opcode field width
INSTRUCTIONWIDTH, 24, instruction width
IMMWIDTH, 16, immediate field width (instruction[IMMWIDTH-1:0])
SIGNEXT, 0, 0 = zero-extend immediate, 1 = sign-extend

Ports:
clock  input  1  single clock; all state on rising edge
reset  input  1  asynchronous, active-low reset
instruction  input  INSTRUCTIONWIDTH  instruction from fetch
PC  input  WIDTH  PC associated with instruction
inValid  input  1  instruction/PC valid
inReady  output  1  stage accepts instruction this cycle (combinational)
writeEnable  input  1  writeback enable
writeAddress  input  ADDRESSWIDTH  writeback register
dataToSave  input  WIDTH  writeback data
exMemRead  input  1  instruction currently in EX is a load
exDestAddress  input  ADDRESSWIDTH  destination of instruction in EX
flush  input  1  discard contents of this stage (branch taken)
outReady  input  1  EX accepts pipeline register contents
outValid  output  1  pipeline register holds valid instruction
opcode  output  OPCODEWIDTH  registered opcode
regDestinationAddress, reg1Address, reg2Address  output  ADDRESSWIDTH each  registered addresses
reg1Content, reg2Content  output  WIDTH each  registered operand values
inmediate  output  WIDTH  registered extended immediate
pcOut  output  WIDTH  registered PC

Behaviour:
- Field extraction (combinational):
  - opcode = instruction[IW-1 -: OW]
  - rd = next ADDRESSWIDTH bits below opcode, then rs1, then rs2
  - Defaults give opcode[23:20], rd[19:16], rs1[15:12], rs2[11:8], imm[15:0]
- Immediate: low IMMWIDTH bits, zero- or sign-extended to WIDTH per SIGNEXT.
- Register file: REGNUM x WIDTH.
  - Written on rising clock when writeEnable and writeAddress != REGNUM-1.
  - Writes to REGNUM-1 are ignored.
  - Writes to addresses >= REGNUM are ignored.
- Read rules, per port, in priority order:
  - address == REGNUM-1 returns PC input.
  - writeEnable && writeAddress == address returns dataToSave (bypass).
  - Otherwise returns the stored value.
  - Out-of-range address returns 0.
- Hazard: hazard = inValid && exMemRead && exDestAddress != REGNUM-1 && (rs1 == exDestAddress || rs2 == exDestAddress).
- advance = !outValid || outReady.
- inReady = advance && !hazard.
- Pipeline register update, in priority order:
  1. reset low: all outputs and all registers cleared to 0 asynchronously; outValid = 0.
  2. flush: outValid <= 0; data fields do not care (hold). Any instruction presented that cycle is not accepted; inReady is still driven but the caller must re-present it.
  3. advance && hazard: bubble, outValid <= 0, input held by fetch.
  4. advance: capture all decoded fields; outValid <= inValid.
  5. else hold all outputs unchanged.
- Latency: one cycle from an accepted instruction to outValid.
- Full throughput when outReady is held high and there are no hazards.
- Writeback is independent of stall/flush/handshake and occurs even while the stage holds.
- Reset mid-operation: the in-flight instruction is lost; the register file is zeroed.
- Reset value of every output: 0; inReady reflects combinational logic (1 after reset with no hazard).

Test Plan:
- Reset then issue 0x2_3_4_5xx (opcode 2, rd 3, rs1 4, rs2 5) with regs cleared, outReady=1 -> next cycle outValid=1, opcode=2, rd=3, reg1Content=0, inmediate=0x45xx.
- Write r4=0xDEADBEEF with writeEnable in the same cycle an instruction reads rs1=4 -> reg1Content=0xDEADBEEF (bypass).
- rs1=15, PC=0x100 -> reg1Content=0x100; writeEnable to r15 with 0x5 -> later read of r15 still returns PC.
- exMemRead=1, exDestAddress=4, instruction rs2=4 -> inReady=0; next edge outValid=0; drop exMemRead -> instruction accepted next cycle.
- outValid=1, outReady=0 for 3 cycles -> outputs stable, inReady=0; flush asserted -> outValid=0 next edge.
- SIGNEXT=1 with imm 0x8001 -> inmediate=0xFFFF8001; SIGNEXT=0 -> 0x00008001.
- Assert reset low mid-stream while outValid=1 -> outputs 0 immediately; a subsequent read of a previously written register returns 0.
